// File: rtl/iir_pkg.sv
// Shared definitions for the serial all-pole IIR filter family.
//   Q_FRAC / ROUND_CONST : fractional bits of the Q1.15 coefficients and the
//                          half-LSB constant used for round-half-up.
//   sample_t / coeff_t / acc_t : default-width sample, coefficient, accumulator.
//   state_t   : sequencer states of the serial MAC.
//   A_DEFAULT : default feedback taps a[1..8] (a[1] = -0.5, i.e. y += 0.5*y[n-1]).
package iir_pkg;

  localparam int Q_FRAC      = 15;
  localparam int ROUND_CONST = 1 << (Q_FRAC - 1);

  localparam int N_DEF       = 24;
  localparam int N_COEFF_DEF = 16;
  localparam int N_TAPS_DEF  = 9;
  localparam int ACC_W_DEF   = N_DEF + N_COEFF_DEF + $clog2(N_TAPS_DEF) + 1;

  typedef logic signed [N_DEF-1:0]       sample_t;
  typedef logic signed [N_COEFF_DEF-1:0] coeff_t;
  typedef logic signed [ACC_W_DEF-1:0]   acc_t;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

  localparam coeff_t A_DEFAULT [1:N_TAPS_DEF-1] = '{
    16'hC000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/iir_sat_round.sv
// Combinational output stage: converts a Q.15-scaled accumulator into an
// integer sample with round-half-up, then clamps to the sample range.
//   acc    : signed accumulator, ACC_W bits, Q_FRAC fractional bits
//   sample : rounded, saturated signed N-bit result
module iir_sat_round
  import iir_pkg::*;
#(
  parameter int N     = 24,
  parameter int ACC_W = 44
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [N-1:0]     sample
);

  localparam logic signed [ACC_W-1:0] RC   = ACC_W'(ROUND_CONST);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;

  // Adding half an LSB before the arithmetic (floor) shift gives round-half-up,
  // so -1.5 -> -1 and +0.5 -> +1; the resulting limit cycles are intentional.
  assign biased  = acc + RC;
  assign shifted = biased >>> Q_FRAC;

  always_comb begin
    if (shifted > MAXV) begin
      sample = MAXV[N-1:0];
    end else if (shifted < MINV) begin
      sample = MINV[N-1:0];
    end else begin
      sample = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/iir_allpole_serial.sv
// Serial-MAC all-pole IIR: y[n] = x[n] - sum_{k=1}^{N_taps-1} a[k]*y[n-k].
// One multiplier is time-shared, one tap per clock, under a small FSM.
//   clk, reset_n  : clock, asynchronous active-low reset
//   clear         : synchronous flush of history / in-flight sample
//   data_in, in_valid, in_ready    : input sample handshake (in_ready only in IDLE)
//   data_out, out_valid, out_ready : output sample handshake (held until taken)
module iir_allpole_serial
  import iir_pkg::*;
#(
  parameter int N       = 24,
  parameter int N_coeff = 16,
  parameter int N_taps  = 9,
  parameter logic signed [N_coeff-1:0] A_COEF [1:N_taps-1] = A_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic signed [N-1:0] data_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] data_out,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int ACC_W  = N + N_coeff + $clog2(N_taps) + 1;
  localparam int PROD_W = N + N_coeff;
  localparam int K_W    = $clog2(N_taps);

  state_t                    state_reg, state_next;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic [K_W-1:0]            k_reg, k_next;
  logic signed [N-1:0]       data_out_reg, data_out_next;
  logic                      out_valid_reg, out_valid_next;
  logic                      hist_shift;
  logic                      hist_clear;

  logic signed [N-1:0]       yh [0:N_taps-2];
  logic signed [N_coeff-1:0] coeff_sel;
  logic signed [N-1:0]       hist_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_load;
  logic signed [N-1:0]       rounded;

  // Tap select: k addresses coefficient a[k] and history y[n-k] (yh[k-1]).
  always_comb begin
    coeff_sel = '0;
    hist_sel  = '0;
    for (int i = 1; i < N_taps; i++) begin
      if (k_reg == K_W'(i)) begin
        coeff_sel = A_COEF[i];
        hist_sel  = yh[i-1];
      end
    end
  end

  assign prod     = {{N{coeff_sel[N_coeff-1]}}, coeff_sel} *
                    {{N_coeff{hist_sel[N-1]}}, hist_sel};
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // x[n] enters with a[0] = 1.0, i.e. aligned to the Q.15 product scale.
  assign acc_load = {{(ACC_W-N-Q_FRAC){data_in[N-1]}}, data_in, {Q_FRAC{1'b0}}};

  iir_sat_round #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_sat_round (
    .acc    (acc_reg),
    .sample (rounded)
  );

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    k_next         = k_reg;
    data_out_next  = data_out_reg;
    out_valid_next = out_valid_reg;
    hist_shift     = 1'b0;
    hist_clear     = 1'b0;
    if (clear) begin
      state_next     = IDLE;
      acc_next       = '0;
      out_valid_next = 1'b0;
      hist_clear     = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_next   = acc_load;
            k_next     = K_W'(1);
            state_next = MAC;
          end
        end
        MAC: begin
          acc_next = acc_reg - prod_ext;
          k_next   = k_reg + K_W'(1);
          if (k_reg == K_W'(N_taps - 1)) begin
            state_next = ROUND;
          end
        end
        ROUND: begin
          data_out_next  = rounded;
          hist_shift     = 1'b1;
          out_valid_next = 1'b1;
          state_next     = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      k_reg         <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      k_reg         <= k_next;
      data_out_reg  <= data_out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // History shifts only when a result is produced; it stores the saturated
  // value so the fed-back sample equals the emitted one.
  for (genvar gi = 0; gi < N_taps - 1; gi++) begin : g_hist
    logic signed [N-1:0] stage_reg;
    logic signed [N-1:0] stage_in;
    if (gi == 0) begin : g_head
      assign stage_in = rounded;
    end else begin : g_body
      assign stage_in = yh[gi-1];
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage_reg <= '0;
      end else if (hist_clear) begin
        stage_reg <= '0;
      end else if (hist_shift) begin
        stage_reg <= stage_in;
      end
    end
    assign yh[gi] = stage_reg;
  end

  assign in_ready  = (state_reg == IDLE);
  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_iir_allpole_serial.sv
module tb_iir_allpole_serial;
  import iir_pkg::*;

  localparam logic signed [15:0] CB [1:8] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000,
                                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic signed [15:0] CC [1:8] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000,
                                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic signed [15:0] CD [1:8] = '{16'h2000, 16'hF000, 16'h0800, 16'hFC00,
                                               16'h0400, 16'hFE00, 16'h0100, 16'hFF80};

  logic clk = 1'b0;
  logic reset_n, clear, in_valid, out_ready;
  logic signed [23:0] data_in;
  logic signed [23:0] dout [4];
  logic ov [4];
  logic ir [4];

  int total = 0;
  int bad   = 0;
  int xn    = 0;

  longint cm  [4][8];
  longint yhm [4][8];

  always #5 clk = ~clk;

  iir_allpole_serial u_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in), .in_valid(in_valid),
    .in_ready(ir[0]), .data_out(dout[0]), .out_valid(ov[0]), .out_ready(out_ready));
  iir_allpole_serial #(.A_COEF(CB)) u_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in), .in_valid(in_valid),
    .in_ready(ir[1]), .data_out(dout[1]), .out_valid(ov[1]), .out_ready(out_ready));
  iir_allpole_serial #(.A_COEF(CC)) u_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in), .in_valid(in_valid),
    .in_ready(ir[2]), .data_out(dout[2]), .out_valid(ov[2]), .out_ready(out_ready));
  iir_allpole_serial #(.A_COEF(CD)) u_d (
    .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in), .in_valid(in_valid),
    .in_ready(ir[3]), .data_out(dout[3]), .out_valid(ov[3]), .out_ready(out_ready));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: y = sat(round_half_up((x*2^15 - sum a[k]*y[n-k]) / 2^15))
  function automatic longint model_calc(int inst, longint x);
    longint acc;
    acc = x * 32768;
    for (int k = 0; k < 8; k++) acc -= cm[inst][k] * yhm[inst][k];
    acc = (acc + 16384) >>> 15;
    if (acc > 8388607) acc = 8388607;
    else if (acc < -8388608) acc = -8388608;
    return acc;
  endfunction

  task automatic model_push(input int inst, input longint y);
    for (int k = 7; k > 0; k--) yhm[inst][k] = yhm[inst][k-1];
    yhm[inst][0] = y;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) yhm[i][k] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_zero();
  endtask

  // One full sample: accept, wait for result, hold for 'hold' cycles, hand off.
  task automatic xact(input longint x, input int hold);
    int lat;
    longint exp [4];
    logic signed [23:0] held;
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_idle", ir[i], 1);
      exp[i] = model_calc(i, x);
    end
    data_in  = x[23:0];
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    data_in  = 24'($urandom);
    chk("in_ready_busy", ir[0], 0);
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", lat, 9);
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", ov[i], 1);
      chk("data_out", dout[i], exp[i]);
    end
    held = dout[0];
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      step();
      chk("hold_data", dout[0], held);
      chk("hold_valid", ov[0], 1);
      chk("hold_in_ready", ir[0], 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("handoff_valid", ov[i], 0);
      chk("handoff_ready", ir[i], 1);
      model_push(i, exp[i]);
    end
    $display("xact %0d: x=%0d y=%0d/%0d/%0d/%0d", xn, x, dout[0], dout[1], dout[2], dout[3]);
    xn++;
  endtask

  task automatic impulse_run();
    xact(4096, 0);
    chk("impulse_0", dout[0], 4096);
    for (int n = 1; n < 15; n++) begin
      xact(0, 0);
      chk("impulse_tail", dout[0], (n <= 12) ? (64'sd4096 >>> n) : 64'sd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      cm[0][k] = (k == 0) ? -16384 : 0;
      cm[1][k] = CB[k+1];
      cm[2][k] = CC[k+1];
      cm[3][k] = CD[k+1];
    end
    model_zero();

    // Reset state; in_valid during reset must be ignored.
    reset_n = 1'b0; clear = 1'b0; data_in = 24'sd777; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_in_ready", ir[i], 1);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_data_out", dout[i], 0);
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();
    chk("post_rst_idle", ir[0], 1);

    // Impulse response of y = x + 0.5*y[n-1]
    impulse_run();

    // Long hold with out_ready low
    xact(1000, 5);
    xact(-3000, 3);

    // Saturation with the integrator instance
    do_clear();
    xact(64'sh400000, 0);
    chk("sat_first", dout[1], 64'sh400000);
    xact(64'sh400000, 0);
    chk("sat_pos", dout[1], 64'sh7FFFFF);
    xact(64'sh400000, 1);
    chk("sat_pos_hold", dout[1], 64'sh7FFFFF);
    for (int n = 0; n < 5; n++) xact(-64'sh400000, 0);
    chk("sat_neg", dout[1], -64'sd8388608);

    // Negative rounding
    do_clear();
    xact(-5, 0);
    chk("neg_exact", dout[0], -5);
    do_clear();
    xact(3, 0);
    xact(0, 0);
    chk("neg_round", dout[2], -1);

    // Randomized samples
    do_clear();
    for (int n = 0; n < 24; n++) begin
      longint x;
      if ($urandom_range(0, 4) == 0) x = longint'($urandom_range(0, 16777215)) - 8388608;
      else x = longint'($urandom_range(0, 20000)) - 10000;
      xact(x, $urandom_range(0, 2));
    end

    // clear during MAC of the third sample
    do_clear();
    xact(100, 0);
    xact(200, 0);
    data_in = 24'sd300; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    do_clear();
    begin
      int seen = 0;
      for (int c = 0; c < 14; c++) begin
        if (ov[0] === 1'b1) seen++;
        step();
      end
      chk("clear_no_output", seen, 0);
    end
    // Sample offered together with clear is not accepted
    clear = 1'b1; in_valid = 1'b1; data_in = 24'sd555;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_same_cycle", ir[0], 1);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        if (ov[0] === 1'b1) seen++;
        step();
      end
      chk("clear_same_no_output", seen, 0);
    end
    xact(4096, 0);
    chk("after_clear", dout[0], 4096);

    // Asynchronous reset while in HOLD
    xact(7, 0);
    data_in = 24'sd1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    begin
      int lat = 0;
      while (ov[0] !== 1'b1 && lat < 40) begin
        step();
        lat++;
      end
      chk("pre_rst_latency", lat, 9);
    end
    step(); step();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("async_out_valid", ov[i], 0);
      chk("async_data_out", dout[i], 0);
      chk("async_in_ready", ir[i], 1);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_zero();
    impulse_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
